// File: rtl/flappy_game_ctrl.sv
// Game sequencer for the Flappy-VGA flight physics engine: frame tick, engine
// Start/Stop/Ack handshake, per-frame jump requests, death detection and scoring.
module flappy_game_ctrl #(
   parameter int TICK_DIV    = 833333,
   parameter int TICK_W      = 20,
   parameter int FLOOR_Y     = 0,
   parameter int CEIL_Y      = 470,
   parameter int DEATH_TICKS = 30
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              BtnIn,
   input  logic              Collide,
   input  logic              PipePassed,
   input  logic signed [9:0] Bird_Y,
   input  logic              q_Initial,
   input  logic              q_Flight,
   input  logic              q_Stop,
   output logic              PhysTick,
   output logic              Start,
   output logic              Stop,
   output logic              Ack,
   output logic              BtnPress,
   output logic [7:0]        Score,
   output logic [7:0]        Best,
   output logic              q_Idle,
   output logic              q_Play,
   output logic              q_Dying,
   output logic              q_Over
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_PLAY  = 4'b0010,
      S_DYING = 4'b0100,
      S_OVER  = 4'b1000
   } state_t;

   localparam logic signed [9:0] FLOOR_S    = 10'(FLOOR_Y);
   localparam logic signed [9:0] CEIL_S     = 10'(CEIL_Y);
   localparam logic [7:0]        DEATH_INIT = 8'(DEATH_TICKS);
   localparam logic [TICK_W-1:0] DIV_LAST   = TICK_W'(TICK_DIV - 1);

   state_t            state, state_d;
   logic [TICK_W-1:0] div_cnt;
   logic              tick_now;
   logic              btn_q;
   logic              press;
   logic              dead;
   logic              pending, pending_d;
   logic [7:0]        death_cnt, death_cnt_d;
   logic [7:0]        score_d, best_d;
   logic              start_d, ack_d, btn_press_d;

   // The engine's stop flag is not needed to sequence the game.
   logic unused_q_stop;
   assign unused_q_stop = q_Stop;

   assign tick_now = (div_cnt == DIV_LAST);
   assign press    = BtnIn & ~btn_q;
   // Bird_Y is signed, so a negative height falls through the floor test.
   assign dead     = q_Flight & (Collide | (Bird_Y <= FLOOR_S) | (Bird_Y >= CEIL_S));

   always_ff @(posedge Clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d     = state;
      pending_d   = pending;
      death_cnt_d = death_cnt;
      score_d     = Score;
      best_d      = Best;
      start_d     = 1'b0;
      ack_d       = 1'b0;
      btn_press_d = 1'b0;
      case (state)
         S_IDLE: begin
            if (press && q_Initial) begin
               start_d   = 1'b1;
               score_d   = 8'd0;
               pending_d = 1'b0;
               state_d   = S_PLAY;
            end
         end
         S_PLAY: begin
            if (PipePassed && (Score != 8'hFF)) score_d = Score + 8'd1;
            if (dead) begin
               state_d     = S_DYING;
               death_cnt_d = DEATH_INIT;
               pending_d   = 1'b0;
            end else if (tick_now && (pending || press)) begin
               btn_press_d = 1'b1;
               pending_d   = 1'b0;
            end else if (press) begin
               pending_d = 1'b1;
            end
         end
         S_DYING: begin
            if (tick_now) begin
               death_cnt_d = death_cnt - 8'd1;
               if (death_cnt <= 8'd1) begin
                  state_d = S_OVER;
                  if (Score > Best) best_d = Score;
               end
            end
         end
         S_OVER: begin
            if (press) begin
               ack_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge Clk) begin
      if (reset) begin
         div_cnt   <= '0;
         PhysTick  <= 1'b0;
         btn_q     <= 1'b0;
         pending   <= 1'b0;
         death_cnt <= 8'd0;
         Score     <= 8'd0;
         Best      <= 8'd0;
         Start     <= 1'b0;
         Ack       <= 1'b0;
         BtnPress  <= 1'b0;
         Stop      <= 1'b0;
      end else begin
         div_cnt   <= tick_now ? '0 : div_cnt + 1'b1;
         PhysTick  <= tick_now;
         btn_q     <= BtnIn;
         pending   <= pending_d;
         death_cnt <= death_cnt_d;
         Score     <= score_d;
         Best      <= best_d;
         Start     <= start_d;
         Ack       <= ack_d;
         BtnPress  <= btn_press_d;
         Stop      <= (state_d == S_DYING);
      end
   end

   assign q_Idle  = state[0];
   assign q_Play  = state[1];
   assign q_Dying = state[2];
   assign q_Over  = state[3];

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl: directed sequences, a death-boundary
// vector table and random stimulus, all scored against a frame-level game model.
module tb_flappy_game_ctrl;

   localparam int TD = 4;
   localparam int DT = 2;

   localparam int M_IDLE  = 0;
   localparam int M_PLAY  = 1;
   localparam int M_DYING = 2;
   localparam int M_OVER  = 3;

   logic              Clk = 1'b0;
   logic              reset, BtnIn, Collide, PipePassed;
   logic signed [9:0] Bird_Y;
   logic              q_Initial, q_Flight, q_Stop;
   logic              PhysTick, Start, Stop, Ack, BtnPress;
   logic [7:0]        Score, Best;
   logic              q_Idle, q_Play, q_Dying, q_Over;

   flappy_game_ctrl #(
      .TICK_DIV(TD), .TICK_W(3), .FLOOR_Y(0), .CEIL_Y(470), .DEATH_TICKS(DT)
   ) dut (
      .Clk(Clk), .reset(reset), .BtnIn(BtnIn), .Collide(Collide),
      .PipePassed(PipePassed), .Bird_Y(Bird_Y), .q_Initial(q_Initial),
      .q_Flight(q_Flight), .q_Stop(q_Stop), .PhysTick(PhysTick), .Start(Start),
      .Stop(Stop), .Ack(Ack), .BtnPress(BtnPress), .Score(Score), .Best(Best),
      .q_Idle(q_Idle), .q_Play(q_Play), .q_Dying(q_Dying), .q_Over(q_Over)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Game model: frame ticks come from the number of cycles since reset.
   int m_mode, m_age, m_dcnt, m_score, m_best;
   bit m_prev, m_pend, m_tick, m_start, m_stop, m_ack, m_bp;

   typedef struct {
      logic signed [9:0] by;
      logic              col;
      logic              fl;
      logic              exp_dead;
   } dvec_t;
   dvec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic model_step();
      bit press;
      int by;
      if (reset) begin
         m_mode = M_IDLE; m_age = 0; m_prev = 0; m_pend = 0; m_dcnt = 0;
         m_score = 0; m_best = 0;
         m_tick = 0; m_start = 0; m_ack = 0; m_bp = 0;
      end else begin
         m_age++;
         m_tick  = (m_age % TD == 0);
         press   = BtnIn && !m_prev;
         m_prev  = BtnIn;
         m_start = 0; m_ack = 0; m_bp = 0;
         by      = Bird_Y;
         case (m_mode)
            M_IDLE: if (press && q_Initial) begin
               m_start = 1; m_score = 0; m_pend = 0; m_mode = M_PLAY;
            end
            M_PLAY: begin
               if (PipePassed) m_score = (m_score >= 255) ? 255 : m_score + 1;
               if (q_Flight && (Collide || by <= 0 || by >= 470)) begin
                  m_mode = M_DYING; m_dcnt = DT; m_pend = 0;
               end else if (m_tick && (m_pend || press)) begin
                  m_bp = 1; m_pend = 0;
               end else if (press) m_pend = 1;
            end
            M_DYING: if (m_tick) begin
               m_dcnt--;
               if (m_dcnt == 0) begin
                  m_mode = M_OVER;
                  if (m_score > m_best) m_best = m_score;
               end
            end
            default: if (press) begin
               m_ack = 1; m_mode = M_IDLE;
            end
         endcase
      end
      m_stop = (m_mode == M_DYING);
   endtask

   function automatic logic [8:0] dut_ctrl();
      return {PhysTick, Start, Stop, Ack, BtnPress, q_Idle, q_Play, q_Dying, q_Over};
   endfunction

   function automatic logic [8:0] model_ctrl();
      return {m_tick, m_start, m_stop, m_ack, m_bp, m_mode == M_IDLE, m_mode == M_PLAY,
              m_mode == M_DYING, m_mode == M_OVER};
   endfunction

   // One clock: inputs already set, advance model, sample DUT 1 time unit after the edge.
   task automatic cyc();
      model_step();
      @(posedge Clk);
      #1;
      check("model_ctrl", 32'(dut_ctrl()), 32'(model_ctrl()));
      check("model_score", 32'(Score), 32'(m_score));
      check("model_best", 32'(Best), 32'(m_best));
   endtask

   task automatic do_reset(input int n);
      reset = 1; BtnIn = 0;
      repeat (n) cyc();
      reset = 0;
   endtask

   task automatic start_game();
      BtnIn = 0; q_Initial = 1; q_Flight = 0; Collide = 0;
      cyc();
      BtnIn = 1;
      cyc();
      check("start_pulse", 32'(Start), 32'd1);
      BtnIn = 0;
      cyc();
      check("start_in_play", 32'(q_Play), 32'd1);
   endtask

   task automatic wait_phase(input int p);
      for (int i = 0; i < 2 * TD && ((m_age + 1) % TD) != p; i++) cyc();
   endtask

   task automatic run_to_over(output int ticks);
      ticks = 0;
      for (int i = 0; i < 40 && !q_Over; i++) begin
         cyc();
         if (PhysTick) ticks++;
      end
      check("reach_over", 32'(q_Over), 32'd1);
   endtask

   initial begin
      int ticks;
      tbl[0] = '{-10'sd1,   1'b0, 1'b1, 1'b1};
      tbl[1] = '{10'sd0,    1'b0, 1'b1, 1'b1};
      tbl[2] = '{10'sd1,    1'b0, 1'b1, 1'b0};
      tbl[3] = '{10'sd469,  1'b0, 1'b1, 1'b0};
      tbl[4] = '{10'sd470,  1'b0, 1'b1, 1'b1};
      tbl[5] = '{10'sd511,  1'b0, 1'b1, 1'b1};
      tbl[6] = '{-10'sd512, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{10'sd200,  1'b1, 1'b1, 1'b1};
      tbl[8] = '{10'sd200,  1'b1, 1'b0, 1'b0};
      tbl[9] = '{10'sd470,  1'b0, 1'b0, 1'b0};

      reset = 1; BtnIn = 0; Collide = 0; PipePassed = 0; Bird_Y = 10'sd200;
      q_Initial = 1; q_Flight = 0; q_Stop = 0;

      // Reset state and frame divider
      do_reset(3);
      check("reset_outputs", 32'(dut_ctrl()), 32'h008);
      check("reset_score", 32'(Score), 32'd0);
      for (int k = 1; k <= 12; k++) begin
         cyc();
         check("div_tick", 32'(PhysTick), 32'(k % TD == 0));
      end

      // Start handshake, q_Initial=1 then q_Initial=0
      do_reset(3);
      repeat (10) cyc();
      BtnIn = 1;
      cyc();
      check("start_at_11", 32'(Start), 32'd1);
      check("play_at_11", 32'(q_Play), 32'd1);
      cyc();
      check("start_one_cycle", 32'(Start), 32'd0);
      check("play_held", 32'(q_Play), 32'd1);
      do_reset(1);
      q_Initial = 0;
      cyc();
      BtnIn = 1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("no_start_uninit", 32'(Start), 32'd0);
         check("stay_idle", 32'(q_Idle), 32'd1);
      end
      BtnIn = 0; q_Initial = 1;

      // Press collapsing
      start_game();
      wait_phase(1);
      BtnIn = 1; cyc(); check("press_no_bp_a", 32'(BtnPress), 32'd0);
      BtnIn = 0; cyc();
      BtnIn = 1; cyc(); check("press_no_bp_b", 32'(BtnPress), 32'd0);
      BtnIn = 0; cyc();
      check("collapsed_tick", 32'(PhysTick), 32'd1);
      check("collapsed_bp", 32'(BtnPress), 32'd1);
      for (int k = 0; k < TD; k++) begin
         cyc();
         check("no_carry", 32'(BtnPress), 32'd0);
      end
      wait_phase(0);
      BtnIn = 1; cyc();
      check("same_tick_bp", 32'(BtnPress), 32'd1);
      check("same_tick_tick", 32'(PhysTick), 32'd1);
      BtnIn = 0;
      for (int k = 0; k < TD; k++) begin
         cyc();
         check("same_tick_no_carry", 32'(BtnPress), 32'd0);
      end

      // Score saturation, collision death, Best update
      for (int k = 0; k < 300; k++) begin
         PipePassed = 1; cyc();
         PipePassed = 0; cyc();
      end
      check("score_sat", 32'(Score), 32'd255);
      q_Flight = 1; Collide = 1;
      cyc();
      check("death_stop", 32'(Stop), 32'd1);
      check("death_dying", 32'(q_Dying), 32'd1);
      q_Flight = 0; Collide = 0;
      run_to_over(ticks);
      check("dying_ticks", 32'(ticks), 32'(DT));
      check("over_stop_low", 32'(Stop), 32'd0);
      check("best_255", 32'(Best), 32'd255);

      // Ack back to idle
      BtnIn = 1; cyc();
      check("ack_pulse", 32'(Ack), 32'd1);
      check("ack_idle", 32'(q_Idle), 32'd1);
      BtnIn = 0; cyc();
      check("ack_one_cycle", 32'(Ack), 32'd0);

      // Second game: floor death with Score 5 keeps Best
      start_game();
      for (int k = 0; k < 5; k++) begin
         PipePassed = 1; cyc();
         PipePassed = 0; cyc();
      end
      check("score_5", 32'(Score), 32'd5);
      Bird_Y = -10'sd1; q_Flight = 1;
      cyc();
      check("floor_dying", 32'(q_Dying), 32'd1);
      Bird_Y = 10'sd200; q_Flight = 0;
      run_to_over(ticks);
      check("best_kept", 32'(Best), 32'd255);
      check("score_held", 32'(Score), 32'd5);
      BtnIn = 1; cyc(); BtnIn = 0; cyc();

      // Reset while dying
      start_game();
      PipePassed = 1; cyc(); PipePassed = 0;
      q_Flight = 1; Collide = 1; cyc();
      q_Flight = 0; Collide = 0; cyc();
      check("pre_reset_dying", 32'(q_Dying), 32'd1);
      reset = 1; cyc();
      check("rst_idle", 32'(q_Idle), 32'd1);
      check("rst_stop", 32'(Stop), 32'd0);
      check("rst_score", 32'(Score), 32'd0);
      check("rst_best", 32'(Best), 32'd0);
      reset = 0;

      // Death boundary table
      foreach (tbl[i]) begin
         do_reset(1);
         start_game();
         Bird_Y = tbl[i].by; Collide = tbl[i].col; q_Flight = tbl[i].fl;
         cyc();
         check("tbl_dying", 32'(q_Dying), 32'(tbl[i].exp_dead));
         check("tbl_stop", 32'(Stop), 32'(tbl[i].exp_dead));
         Bird_Y = 10'sd200; Collide = 0; q_Flight = 0;
      end

      // Random stimulus against the model
      do_reset(2);
      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 2) == 0) BtnIn = ~BtnIn;
         Collide    = ($urandom_range(0, 39) == 0);
         PipePassed = ($urandom_range(0, 3) == 0);
         q_Initial  = ($urandom_range(0, 7) != 0);
         q_Flight   = ($urandom_range(0, 3) != 0);
         q_Stop     = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 29) == 0) Bird_Y = 10'($urandom_range(0, 1023));
         else Bird_Y = 10'($urandom_range(1, 469));
         cyc();
      end
      reset = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
